// File: rtl/pill_miss_tracker.sv
// pill_miss_tracker: per-pill IDLE/WAIT/DUE/TAKEN tracker with saturating miss counters.
// Optional consecutive-miss escalation is built when PMT_STREAK_EN is defined.

module pill_miss_tracker #(
  parameter int NUM_PILLS    = 3,
  parameter int DUR_W        = 4,
  parameter int MISS_W       = 4,
  parameter int STREAK_LIMIT = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        run,
  input  logic                        clear_counts,
  input  logic                        take_pulse,
  input  logic [NUM_PILLS*DUR_W-1:0]  pill_duration,
  input  logic [NUM_PILLS*DUR_W-1:0]  pill_interval,
  output logic [NUM_PILLS-1:0]        alarm,
  output logic [NUM_PILLS-1:0]        ack,
  output logic [NUM_PILLS*MISS_W-1:0] miss_count,
  output logic [MISS_W+2:0]           total_miss,
  output logic                        escalate
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DUE   = 2'd2,
    ST_TAKEN = 2'd3
  } state_t;

  localparam logic [MISS_W-1:0] MISS_MAX = {MISS_W{1'b1}};
  localparam logic [MISS_W-1:0] MISS_ONE = MISS_W'(1'b1);

  state_t               state_r     [NUM_PILLS];
  state_t               state_nxt_s [NUM_PILLS];
  logic [MISS_W-1:0]    miss_cnt_r  [NUM_PILLS];
  logic [NUM_PILLS-1:0] dur_zero_s;
  logic [NUM_PILLS-1:0] enable_s;
  logic [NUM_PILLS-1:0] miss_s;
  logic [NUM_PILLS-1:0] alarm_nxt_s;
  logic [NUM_PILLS-1:0] ack_nxt_s;
  logic [NUM_PILLS-1:0] alarm_r;
  logic [NUM_PILLS-1:0] ack_r;

  if (NUM_PILLS < 1 || NUM_PILLS > 8 || STREAK_LIMIT < 1) begin : g_param_check
    $error("pill_miss_tracker: NUM_PILLS must be 1..8 and STREAK_LIMIT >= 1");
  end

  // A pill is only tracked while the system runs and its interval is non-zero.
  for (genvar g = 0; g < NUM_PILLS; g++) begin : g_pill
    assign dur_zero_s[g] = (pill_duration[g*DUR_W +: DUR_W] == {DUR_W{1'b0}});
    assign enable_s[g]   = run & (pill_interval[g*DUR_W +: DUR_W] != {DUR_W{1'b0}});
    assign miss_count[g*MISS_W +: MISS_W] = miss_cnt_r[g];
  end

  // State register for every pill channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PILLS; i++) state_r[i] <= ST_IDLE;
    end else begin
      for (int i = 0; i < NUM_PILLS; i++) state_r[i] <= state_nxt_s[i];
    end
  end

  // Next-state logic; a miss is the DUE->WAIT transition without a take.
  always_comb begin
    miss_s = {NUM_PILLS{1'b0}};
    for (int i = 0; i < NUM_PILLS; i++) begin
      state_nxt_s[i] = state_r[i];
      if (!enable_s[i]) begin
        state_nxt_s[i] = ST_IDLE;
      end else begin
        case (state_r[i])
          ST_IDLE:  state_nxt_s[i] = ST_WAIT;
          ST_WAIT: begin
            if (dur_zero_s[i]) state_nxt_s[i] = ST_DUE;
            else               state_nxt_s[i] = ST_WAIT;
          end
          ST_DUE: begin
            if (take_pulse) begin
              state_nxt_s[i] = ST_TAKEN;
            end else if (!dur_zero_s[i]) begin
              state_nxt_s[i] = ST_WAIT;
              miss_s[i]      = 1'b1;
            end else begin
              state_nxt_s[i] = ST_DUE;
            end
          end
          ST_TAKEN: begin
            if (!dur_zero_s[i]) state_nxt_s[i] = ST_WAIT;
            else                state_nxt_s[i] = ST_TAKEN;
          end
          default:  state_nxt_s[i] = ST_IDLE;
        endcase
      end
    end
  end

  // Output decode from the next state so alarm/ack come straight from flops.
  always_comb begin
    alarm_nxt_s = {NUM_PILLS{1'b0}};
    ack_nxt_s   = {NUM_PILLS{1'b0}};
    for (int i = 0; i < NUM_PILLS; i++) begin
      alarm_nxt_s[i] = (state_nxt_s[i] == ST_DUE);
      ack_nxt_s[i]   = (state_nxt_s[i] == ST_TAKEN);
    end
  end

  // Registered alarm/ack outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm_r <= {NUM_PILLS{1'b0}};
      ack_r   <= {NUM_PILLS{1'b0}};
    end else begin
      alarm_r <= alarm_nxt_s;
      ack_r   <= ack_nxt_s;
    end
  end

  assign alarm = alarm_r;
  assign ack   = ack_r;

  // Saturating miss counters; clear wins over a coincident increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PILLS; i++) miss_cnt_r[i] <= {MISS_W{1'b0}};
    end else if (clear_counts) begin
      for (int i = 0; i < NUM_PILLS; i++) miss_cnt_r[i] <= {MISS_W{1'b0}};
    end else begin
      for (int i = 0; i < NUM_PILLS; i++) begin
        if (miss_s[i] && (miss_cnt_r[i] != MISS_MAX)) miss_cnt_r[i] <= miss_cnt_r[i] + MISS_ONE;
      end
    end
  end

  // Sum of the counters; three extra bits cover up to eight pills.
  always_comb begin
    total_miss = {(MISS_W+3){1'b0}};
    for (int i = 0; i < NUM_PILLS; i++) begin
      total_miss = total_miss + {3'b000, miss_cnt_r[i]};
    end
  end

`ifdef PMT_STREAK_EN
  localparam int SW = $clog2(STREAK_LIMIT + 1);
  localparam logic [SW-1:0] STREAK_MAX = {SW{1'b1}};
  localparam logic [SW-1:0] STREAK_LIM = SW'(STREAK_LIMIT);
  localparam logic [SW-1:0] STREAK_ONE = SW'(1'b1);

  logic [SW-1:0] streak_r     [NUM_PILLS];
  logic [SW-1:0] streak_nxt_s [NUM_PILLS];
  logic          escalate_nxt_s;
  logic          escalate_r;

  // Consecutive-miss counters: a take on the pill or a clear restarts the streak.
  always_comb begin
    escalate_nxt_s = 1'b0;
    for (int i = 0; i < NUM_PILLS; i++) begin
      if (clear_counts) begin
        streak_nxt_s[i] = {SW{1'b0}};
      end else if (enable_s[i] && (state_r[i] == ST_DUE) && take_pulse) begin
        streak_nxt_s[i] = {SW{1'b0}};
      end else if (miss_s[i] && (streak_r[i] != STREAK_MAX)) begin
        streak_nxt_s[i] = streak_r[i] + STREAK_ONE;
      end else begin
        streak_nxt_s[i] = streak_r[i];
      end
      escalate_nxt_s = escalate_nxt_s | (streak_nxt_s[i] >= STREAK_LIM);
    end
  end

  // Streak and escalation registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PILLS; i++) streak_r[i] <= {SW{1'b0}};
      escalate_r <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_PILLS; i++) streak_r[i] <= streak_nxt_s[i];
      escalate_r <= escalate_nxt_s;
    end
  end

  assign escalate = escalate_r;
`else
  assign escalate = 1'b0;
`endif

endmodule

// File: tb/tb_pill_miss_tracker.sv
// Self-checking bench for pill_miss_tracker: vector table, corner sequences and
// randomized traffic against a behavioural model of the dose rules.

module tb_pill_miss_tracker;

  localparam int NP   = 3;
  localparam int DW   = 4;
  localparam int MW   = 4;
  localparam int SL   = 3;
  localparam int MMAX = (1 << MW) - 1;
  localparam int SMAX = (1 << $clog2(SL + 1)) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             run;
  logic             clear_counts;
  logic             take_pulse;
  logic [NP*DW-1:0] pill_duration;
  logic [NP*DW-1:0] pill_interval;
  logic [NP-1:0]    alarm;
  logic [NP-1:0]    ack;
  logic [NP*MW-1:0] miss_count;
  logic [MW+2:0]    total_miss;
  logic             escalate;

  pill_miss_tracker #(.NUM_PILLS(NP), .DUR_W(DW), .MISS_W(MW), .STREAK_LIMIT(SL)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .clear_counts(clear_counts),
    .take_pulse(take_pulse), .pill_duration(pill_duration), .pill_interval(pill_interval),
    .alarm(alarm), .ack(ack), .miss_count(miss_count), .total_miss(total_miss),
    .escalate(escalate)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Model: per pill, whether it is being tracked, and its alarm/ack levels.
  bit m_on    [NP];
  bit m_alarm [NP];
  bit m_ack   [NP];
  int m_miss  [NP];
  int m_streak[NP];

  typedef struct {
    bit         run;
    bit         take;
    bit         clr;
    logic [3:0] d0;
    logic [3:0] d1;
    logic [3:0] d2;
    logic [2:0] exp_alarm;
    logic [2:0] exp_ack;
    int         exp_total;
  } vec_t;

  vec_t tbl[18];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin
      m_on[i] = 1'b0; m_alarm[i] = 1'b0; m_ack[i] = 1'b0;
      m_miss[i] = 0;  m_streak[i] = 0;
    end
  endtask

  task automatic model_step(input bit r, input bit tk, input bit cl,
                            input logic [NP*DW-1:0] dur, input logic [NP*DW-1:0] intv);
    for (int i = 0; i < NP; i++) begin
      int  d;
      bit  en;
      bit  missed;
      bit  taken;
      d      = int'(dur[i*DW +: DW]);
      en     = r && (intv[i*DW +: DW] != 0);
      missed = 1'b0;
      taken  = 1'b0;
      if (!en) begin
        m_on[i] = 1'b0; m_alarm[i] = 1'b0; m_ack[i] = 1'b0;
      end else if (!m_on[i]) begin
        m_on[i] = 1'b1;
      end else if (m_alarm[i]) begin
        if (tk) begin
          m_alarm[i] = 1'b0; m_ack[i] = 1'b1; taken = 1'b1;
        end else if (d != 0) begin
          m_alarm[i] = 1'b0; missed = 1'b1;
        end
      end else if (m_ack[i]) begin
        if (d != 0) m_ack[i] = 1'b0;
      end else if (d == 0) begin
        m_alarm[i] = 1'b1;
      end
      if (cl) begin
        m_miss[i] = 0; m_streak[i] = 0;
      end else begin
        if (missed && m_miss[i] < MMAX) m_miss[i]++;
        if (taken) m_streak[i] = 0;
        else if (missed && m_streak[i] < SMAX) m_streak[i]++;
      end
    end
  endtask

  task automatic compare_model();
    int ea, ek, tot, esc;
    ea = 0; ek = 0; tot = 0; esc = 0;
    for (int i = 0; i < NP; i++) begin
      ea  |= int'(m_alarm[i]) << i;
      ek  |= int'(m_ack[i]) << i;
      tot += m_miss[i];
      check($sformatf("miss_count[%0d]", i), int'(miss_count[i*MW +: MW]), m_miss[i]);
`ifdef PMT_STREAK_EN
      if (m_streak[i] >= SL) esc = 1;
`endif
    end
    check("alarm", int'(alarm), ea);
    check("ack", int'(ack), ek);
    check("total_miss", int'(total_miss), tot);
    check("escalate", int'(escalate), esc);
  endtask

  // Drive one cycle from a negedge, clock it, and compare at the next negedge.
  task automatic apply(input bit r, input bit tk, input bit cl,
                       input logic [NP*DW-1:0] dur, input logic [NP*DW-1:0] intv);
    run = r; take_pulse = tk; clear_counts = cl;
    pill_duration = dur; pill_interval = intv;
    model_step(r, tk, cl, dur, intv);
    @(posedge clk);
    @(negedge clk);
    compare_model();
  endtask

  initial begin
    logic [NP*DW-1:0] intv;
    logic [NP*DW-1:0] dur;

    tbl[0]  = '{1'b1, 1'b0, 1'b0, 4'd3, 4'd3, 4'd3, 3'b000, 3'b000, 0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 4'd3, 4'd2, 4'd3, 3'b000, 3'b000, 0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 4'd2, 4'd1, 4'd2, 3'b000, 3'b000, 0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 3'b111, 3'b000, 0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 3'b111, 3'b000, 0};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 3'b000, 3'b111, 0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 3'b000, 3'b111, 0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 4'd5, 4'd0, 4'd0, 3'b000, 3'b110, 0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 4'd5, 4'd5, 4'd4, 3'b000, 3'b000, 0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 4'd0, 4'd5, 4'd0, 3'b101, 3'b000, 0};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 4'd0, 4'd4, 4'd0, 3'b000, 3'b101, 0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 4'd4, 4'd4, 4'd4, 3'b000, 3'b000, 0};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 4'd4, 4'd4, 4'd0, 3'b100, 3'b000, 0};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 4'd4, 4'd4, 4'd4, 3'b000, 3'b000, 1};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 4'd4, 4'd4, 4'd4, 3'b000, 3'b000, 1};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 4'd4, 4'd4, 4'd4, 3'b000, 3'b000, 1};
    tbl[16] = '{1'b1, 1'b1, 1'b0, 4'd4, 4'd4, 4'd4, 3'b000, 3'b000, 1};
    tbl[17] = '{1'b1, 1'b0, 1'b1, 4'd4, 4'd4, 4'd4, 3'b000, 3'b000, 0};

    intv = {4'd4, 4'd5, 4'd5};
    rst_n = 1'b0; run = 1'b0; take_pulse = 1'b0; clear_counts = 1'b0;
    pill_duration = {NP*DW{1'b0}}; pill_interval = intv;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_alarm", int'(alarm), 0);
    check("reset_ack", int'(ack), 0);
    check("reset_total", int'(total_miss), 0);
    rst_n = 1'b1;
    apply(1'b0, 1'b0, 1'b0, {NP*DW{1'b0}}, intv);

    // Take path, simultaneous due, and miss-counted-once through the table.
    for (int k = 0; k < 18; k++) begin
      apply(tbl[k].run, tbl[k].take, tbl[k].clr, {tbl[k].d2, tbl[k].d1, tbl[k].d0}, intv);
      check($sformatf("tbl%0d_alarm", k), int'(alarm), int'(tbl[k].exp_alarm));
      check($sformatf("tbl%0d_ack", k), int'(ack), int'(tbl[k].exp_ack));
      check($sformatf("tbl%0d_total", k), int'(total_miss), tbl[k].exp_total);
    end

    // Async reset while pill 0 is due and has a recorded miss.
    apply(1'b1, 1'b0, 1'b0, {4'd4, 4'd4, 4'd0}, intv);
    apply(1'b1, 1'b0, 1'b0, {4'd4, 4'd4, 4'd3}, intv);
    apply(1'b1, 1'b0, 1'b0, {4'd4, 4'd4, 4'd0}, intv);
    check("pre_rst_alarm", int'(alarm), 1);
    check("pre_rst_miss0", int'(miss_count[MW-1:0]), 1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_alarm", int'(alarm), 0);
    check("rst_ack", int'(ack), 0);
    check("rst_miss", int'(miss_count), 0);
    #3;
    rst_n = 1'b1;
    apply(1'b1, 1'b0, 1'b0, {4'd3, 4'd3, 4'd3}, intv);
    check("post_rst_wait", int'(alarm), 0);
    apply(1'b1, 1'b0, 1'b0, {4'd3, 4'd3, 4'd0}, intv);
    check("post_rst_due", int'(alarm), 1);

    // Clear coinciding with a miss, then 17 misses to saturation, then clear again.
    apply(1'b1, 1'b0, 1'b1, {4'd5, 4'd5, 4'd5}, intv);
    check("clr_vs_miss", int'(total_miss), 0);
    for (int k = 0; k < 17; k++) begin
      apply(1'b1, 1'b0, 1'b0, {4'd5, 4'd5, 4'd0}, intv);
      apply(1'b1, 1'b0, 1'b0, {4'd5, 4'd5, 4'd5}, intv);
    end
    check("sat_miss0", int'(miss_count[MW-1:0]), 15);
    check("sat_total", int'(total_miss), 15);
    apply(1'b1, 1'b0, 1'b0, {4'd5, 4'd5, 4'd0}, intv);
    apply(1'b1, 1'b0, 1'b1, {4'd5, 4'd5, 4'd5}, intv);
    check("sat_clear", int'(total_miss), 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NP; i++) begin
        dur[i*DW +: DW]  = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
        intv[i*DW +: DW] = ($urandom_range(0, 29) == 0) ? 4'd0 : 4'd5;
      end
      apply($urandom_range(0, 49) != 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 59) == 0, dur, intv);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/pill_miss_tracker.md
Name: pill_miss_tracker

Overview:
Parametrised successor of the three-pill taken/missed recorder. Tracks NUM_PILLS independent dose channels against per-pill countdown timers and raises a per-pill alarm when a dose falls due. It acknowledges the patient's take button back to the next-pill timer and keeps a saturating miss counter per pill. Sits between the per-pill countdown timers (next-pill monitor) and the RAM record writer.

Parameters:
NUM_PILLS, 3, number of independent pill channels (1..8)
DUR_W, 4, width of each pill duration and interval field
MISS_W, 4, width of each per-pill miss counter
STREAK_LIMIT, 3, consecutive-miss escalation threshold (used only with PMT_STREAK_EN)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
run  in  1  level; 1 while the system is in its running-time state
clear_counts  in  1  synchronous pulse; zero all miss counters (ROM load from reset state)
take_pulse  in  1  single-cycle debounced take/start button pulse
pill_duration  in  NUM_PILLS*DUR_W  current countdown per pill, pill i at [i*DUR_W +: DUR_W]
pill_interval  in  NUM_PILLS*DUR_W  configured max interval per pill from ROM
alarm  out  NUM_PILLS  1 while pill i is due and not yet taken
ack  out  NUM_PILLS  reload request to the next-pill timer, pill i taken
miss_count  out  NUM_PILLS*MISS_W  per-pill miss counters, same packing as pill_duration
total_miss  out  MISS_W+3  sum of all miss counters, combinational from registers
escalate  out  1  streak alarm (PMT_STREAK_EN only, else tied 0)

Behaviour:
- Reset (rst_n=0, async): every FSM in IDLE; alarm=0, ack=0, miss_count=0, streak counters=0, escalate=0.
- Per-pill FSM, one per channel, states IDLE, WAIT, DUE, TAKEN:
  - IDLE: alarm=0, ack=0. Go to WAIT when run=1 and pill_interval[i]!=0. A zero interval disables the pill, which stays IDLE.
  - WAIT: go to DUE when pill_duration[i]==0.
  - DUE: alarm[i]=1.
    - take_pulse=1 moves the FSM to TAKEN and sets ack[i]=1 on the next edge (1-cycle latency).
    - If pill_duration[i]!=0 with no take_pulse (timer wrapped/reloaded itself), record a miss: miss_count[i] increments once, and the FSM goes to WAIT.
    - take_pulse wins if it coincides with the wrap.
  - TAKEN: alarm=0, ack[i] held at 1. This is the level handshake: ack holds until pill_duration[i]!=0, then ack drops on the same edge the FSM moves to WAIT. No miss is recorded.
- A take_pulse acknowledges every pill in DUE simultaneously. A take_pulse when no pill is in DUE is ignored, with no state change.
- Each miss is counted exactly once per due event, regardless of how many cycles the wrap condition persists.
- miss_count saturates at 2^MISS_W-1; further misses are dropped.
- clear_counts zeroes all miss counters and streak counters. If it coincides with a miss increment, the clear wins (result 0). FSM states are unaffected.
- run=0 forces every FSM to IDLE on the next edge: alarm and ack go to 0, counters hold.
- pill_interval changing to 0 while active forces that pill to IDLE on the next edge.
- total_miss is the unsigned sum of all miss_count fields, zero-extended, and cannot overflow for NUM_PILLS<=8.

Optional Feature:
Macro PMT_STREAK_EN.
- Defined: each pill has a consecutive-miss counter of width $clog2(STREAK_LIMIT+1), saturating.
  - Incremented on every miss, zeroed on every take for that pill.
  - escalate=1 (registered) while any pill's streak is >= STREAK_LIMIT.
  - Cleared by a take on the offending pill, by clear_counts, or by reset.
- Not defined: no streak logic, escalate tied to 0.

Test Plan:
1. Reset mid-DUE. Pill 0 in DUE with alarm[0]=1, then rst_n pulsed low -> alarm, ack and miss_count all 0 immediately. After release and run=1, FSM re-enters WAIT.
2. Take path. run=1, pill1 duration counts 3,2,1,0; take_pulse 2 cycles after reaching 0 -> ack[1]=1 next cycle and held while duration=0. Timer reloads to 5 -> ack[1]=0, miss_count[1]=0.
3. Miss path. Pill2 interval=4, duration reaches 0, no take, then duration jumps to 4 and stays 4 for 3 cycles -> miss_count[2]=1 (not 3), alarm[2] low.
4. Simultaneous due. Pills 0 and 2 both at 0, one take_pulse -> ack=3'b101. Pill 1, still in WAIT, is unaffected.
5. Saturation and clear. MISS_W=4, force 17 misses on pill0 -> miss_count[0]=15, total_miss=15. clear_counts in the same cycle as an 18th miss -> 0.
6. PMT_STREAK_EN with STREAK_LIMIT=3. Three consecutive misses on pill1 -> escalate=1. A following take on pill1 -> escalate=0, miss_count[1] stays 3.
